// File: rtl/rf_pkg.sv
// Shared definitions for the register file with scoreboard.
// Contents:
//   DEF_ADDRSIZE / DEF_WORDSIZE : default address and data widths
//   ZERO_ADDR                   : address of the hardwired-zero register
//   lsb_of()                    : bit offset of one field in a packed per-port vector
package rf_pkg;

    localparam int DEF_ADDRSIZE = 5;
    localparam int DEF_WORDSIZE = 32;
    localparam int ZERO_ADDR    = 0;

    // Port k of a packed vector with fields of 'width' bits starts at k*width.
    function automatic int lsb_of(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset (clears all bits)
//   regwr, rd    : writeback clears busy[rd]
//   issue,
//   issue_rd     : issue sets busy[issue_rd]
//   flush        : clears every busy bit
//   busy_vec     : registered busy bits, bit i belongs to register i
// Update order within one clock: flush, then writeback clear, then issue set,
// so a newly issued producer always survives a same-cycle clear.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int ADDRSIZE = DEF_ADDRSIZE,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       regwr,
    input  logic [ADDRSIZE-1:0]        rd,
    input  logic                       issue,
    input  logic [ADDRSIZE-1:0]        issue_rd,
    input  logic                       flush,
    output logic [(1<<ADDRSIZE)-1:0]   busy_vec
);

    localparam int NREGS = 1 << ADDRSIZE;

    logic [NREGS-1:0] busy_next;
    logic             issue_ok;

    // Register 0 can never become busy when it is hardwired to zero.
    assign issue_ok = issue && !((ZERO_REG != 0) && (issue_rd == ADDRSIZE'(ZERO_ADDR)));

    always_comb begin
        busy_next = busy_vec;
        if (flush) begin
            busy_next = '0;
        end
        if (regwr) begin
            busy_next[rd] = 1'b0;
        end
        if (issue_ok) begin
            busy_next[issue_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_vec <= '0;
        end else begin
            busy_vec <= busy_next;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with write-through bypass, optional
// hardwired-zero register 0 and a pending-write scoreboard.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset (clears data and busy bits)
//   regwr, rd,
//   rddata       : writeback port, stored on the rising edge
//   rs           : NREAD packed read addresses, port k at [k*ADDRSIZE +: ADDRSIZE]
//   rsdata       : NREAD packed read data, port k at [k*WORDSIZE +: WORDSIZE]
//   rsbusy       : per-port busy flag of the addressed register
//   issue,
//   issue_rd     : marks issue_rd pending
//   flush        : clears all pending bits
//   busy_vec     : full scoreboard state
module regfile_sb
    import rf_pkg::*;
#(
    parameter int ADDRSIZE = DEF_ADDRSIZE,
    parameter int WORDSIZE = DEF_WORDSIZE,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        regwr,
    input  logic [ADDRSIZE-1:0]         rd,
    input  logic [WORDSIZE-1:0]         rddata,
    input  logic [NREAD*ADDRSIZE-1:0]   rs,
    output logic [NREAD*WORDSIZE-1:0]   rsdata,
    output logic [NREAD-1:0]            rsbusy,
    input  logic                        issue,
    input  logic [ADDRSIZE-1:0]         issue_rd,
    input  logic                        flush,
    output logic [(1<<ADDRSIZE)-1:0]    busy_vec
);

    localparam int NREGS = 1 << ADDRSIZE;

    logic [WORDSIZE-1:0] regs [NREGS];
    logic                wr_en;

    rf_scoreboard #(
        .ADDRSIZE (ADDRSIZE),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .regwr    (regwr),
        .rd       (rd),
        .issue    (issue),
        .issue_rd (issue_rd),
        .flush    (flush),
        .busy_vec (busy_vec)
    );

    // Writes to the hardwired-zero register are dropped so it stays 0.
    assign wr_en = regwr && !((ZERO_REG != 0) && (rd == ADDRSIZE'(ZERO_ADDR)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[rd] <= rddata;
        end
    end

    for (genvar k = 0; k < NREAD; k++) begin : g_read
        logic [ADDRSIZE-1:0] addr;
        logic [WORDSIZE-1:0] data;
        logic                busy;

        assign addr = rs[lsb_of(k, ADDRSIZE) +: ADDRSIZE];

        // A forwarded value is the one being retired this cycle, so the
        // register is reported not busy even though the bit clears next edge.
        always_comb begin
            data = regs[addr];
            busy = busy_vec[addr];
            if ((ZERO_REG != 0) && (addr == ADDRSIZE'(ZERO_ADDR))) begin
                data = '0;
                busy = 1'b0;
            end else if ((BYPASS != 0) && regwr && (rd == addr)) begin
                data = rddata;
                busy = 1'b0;
            end
        end

        assign rsdata[lsb_of(k, WORDSIZE) +: WORDSIZE] = data;
        assign rsbusy[k] = busy;
    end

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Shared stimulus for the default instance and the no-bypass instance
    logic        regwr = 1'b0;
    logic [4:0]  rd = '0;
    logic [31:0] rddata = '0;
    logic [9:0]  rs = '0;
    logic        issue = 1'b0;
    logic [4:0]  issue_rd = '0;
    logic        flush = 1'b0;

    logic [63:0] d_rsdata, n_rsdata;
    logic [1:0]  d_rsbusy, n_rsbusy;
    logic [31:0] d_busy_vec, n_busy_vec;

    // Small-parameter instance
    logic        s_regwr = 1'b0;
    logic [3:0]  s_rd = '0;
    logic [7:0]  s_rddata = '0;
    logic [11:0] s_rs = '0;
    logic [23:0] s_rsdata;
    logic [2:0]  s_rsbusy;
    logic        s_issue = 1'b0;
    logic [3:0]  s_issue_rd = '0;
    logic        s_flush = 1'b0;
    logic [15:0] s_busy_vec;

    regfile_sb u_def (
        .clk(clk), .rst_n(rst_n), .regwr(regwr), .rd(rd), .rddata(rddata),
        .rs(rs), .rsdata(d_rsdata), .rsbusy(d_rsbusy), .issue(issue),
        .issue_rd(issue_rd), .flush(flush), .busy_vec(d_busy_vec)
    );

    regfile_sb #(.BYPASS(0)) u_nobyp (
        .clk(clk), .rst_n(rst_n), .regwr(regwr), .rd(rd), .rddata(rddata),
        .rs(rs), .rsdata(n_rsdata), .rsbusy(n_rsbusy), .issue(issue),
        .issue_rd(issue_rd), .flush(flush), .busy_vec(n_busy_vec)
    );

    regfile_sb #(.ADDRSIZE(4), .WORDSIZE(8), .NREAD(3)) u_small (
        .clk(clk), .rst_n(rst_n), .regwr(s_regwr), .rd(s_rd), .rddata(s_rddata),
        .rs(s_rs), .rsdata(s_rsdata), .rsbusy(s_rsbusy), .issue(s_issue),
        .issue_rd(s_issue_rd), .flush(s_flush), .busy_vec(s_busy_vec)
    );

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    task automatic expect_val(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_underflow observed=%h expected=<queued value>", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.val) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    // Inputs change 1ns after a rising edge; outputs are sampled 3ns after that.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic idle();
        regwr = 1'b0;
        issue = 1'b0;
        flush = 1'b0;
    endtask

    initial begin
        // Reset held from time 0
        step();
        settle();
        rs = {5'd1, 5'd5};
        expect_val("rst_rsdata", 32'h0);          check(d_rsdata[63:32] | d_rsdata[31:0]);
        expect_val("rst_rsbusy", 32'h0);          check({30'b0, d_rsbusy});
        expect_val("rst_busy_vec", 32'h0);        check(d_busy_vec);
        expect_val("rst_small_busy", 32'h0);      check({16'b0, s_busy_vec});

        // Release reset, write reg5 and mark reg6 busy
        step();
        rst_n = 1'b1;
        step();
        regwr = 1'b1; rd = 5'd5; rddata = 32'hDEADBEEF;
        issue = 1'b1; issue_rd = 5'd6;
        step();
        idle();
        settle();
        expect_val("wr_reg5", 32'hDEADBEEF);      check(d_rsdata[31:0]);
        expect_val("issue_reg6", 32'h0000_0040);  check(d_busy_vec);

        // Asynchronous reset mid-cycle with a write in flight
        regwr = 1'b1; rd = 5'd5; rddata = 32'h11111111;
        issue = 1'b1; issue_rd = 5'd8;
        #1;
        rst_n = 1'b0;
        settle();
        expect_val("midrst_busy_vec", 32'h0);     check(d_busy_vec);
        expect_val("midrst_rsbusy", 32'h0);       check({30'b0, d_rsbusy});
        step();
        idle();
        rst_n = 1'b1;
        settle();
        expect_val("postrst_reg5", 32'h0);        check(d_rsdata[31:0]);
        expect_val("postrst_busy", 32'h0);        check(d_busy_vec);

        // Write/read on both ports, and the dropped write to reg0
        regwr = 1'b1; rd = 5'd3; rddata = 32'h12345678;
        step();
        idle();
        rs = {5'd3, 5'd3};
        settle();
        expect_val("rd_p0_reg3", 32'h12345678);   check(d_rsdata[31:0]);
        expect_val("rd_p1_reg3", 32'h12345678);   check(d_rsdata[63:32]);
        regwr = 1'b1; rd = 5'd0; rddata = 32'hFFFFFFFF;
        rs = {5'd3, 5'd0};
        settle();
        expect_val("zero_same_cycle", 32'h0);     check(d_rsdata[31:0]);
        step();
        idle();
        settle();
        expect_val("zero_after_write", 32'h0);    check(d_rsdata[31:0]);

        // Bypass: reg7 busy, then writeback while reading it
        issue = 1'b1; issue_rd = 5'd7;
        step();
        idle();
        rs = {5'd3, 5'd7};
        settle();
        expect_val("reg7_busy", 32'h1);           check({31'b0, d_rsbusy[0]});
        regwr = 1'b1; rd = 5'd7; rddata = 32'hA5A5A5A5;
        settle();
        expect_val("byp_data", 32'hA5A5A5A5);     check(d_rsdata[31:0]);
        expect_val("byp_busy", 32'h0);            check({31'b0, d_rsbusy[0]});
        expect_val("nobyp_data", 32'h0);          check(n_rsdata[31:0]);
        expect_val("nobyp_busy", 32'h1);          check({31'b0, n_rsbusy[0]});
        step();
        idle();
        settle();
        expect_val("nobyp_after", 32'hA5A5A5A5);  check(n_rsdata[31:0]);
        expect_val("reg7_cleared", 32'h0);        check(d_busy_vec);

        // Issue reg9, then retire it
        issue = 1'b1; issue_rd = 5'd9;
        step();
        idle();
        rs = {5'd9, 5'd7};
        settle();
        expect_val("reg9_busy", 32'h1);           check({31'b0, d_rsbusy[1]});
        regwr = 1'b1; rd = 5'd9; rddata = 32'h00000099;
        settle();
        expect_val("reg9_byp_busy", 32'h0);       check({31'b0, d_rsbusy[1]});
        expect_val("reg9_nobyp_busy", 32'h1);     check({31'b0, n_rsbusy[1]});
        step();
        idle();
        settle();
        expect_val("reg9_retired", 32'h0);        check(d_busy_vec);

        // Issue and writeback to reg9 together: issue wins
        issue = 1'b1; issue_rd = 5'd9;
        regwr = 1'b1; rd = 5'd9; rddata = 32'h0000009A;
        step();
        idle();
        settle();
        expect_val("iss_wb_same", 32'h0000_0200); check(d_busy_vec);

        // Busy 2, 4, 6 then flush with issue of 4
        for (int i = 2; i <= 6; i += 2) begin
            issue = 1'b1; issue_rd = 5'(i);
            step();
        end
        idle();
        settle();
        expect_val("busy_2_4_6_9", 32'h0000_0254); check(d_busy_vec);
        flush = 1'b1; issue = 1'b1; issue_rd = 5'd4;
        step();
        idle();
        settle();
        expect_val("flush_issue4", 32'h0000_0010); check(d_busy_vec);

        // WAW on reg4: one writeback clears it
        issue = 1'b1; issue_rd = 5'd4;
        step();
        idle();
        settle();
        expect_val("waw_busy", 32'h0000_0010);    check(d_busy_vec);
        regwr = 1'b1; rd = 5'd4; rddata = 32'h44444444;
        step();
        idle();
        settle();
        expect_val("waw_cleared", 32'h0);         check(d_busy_vec);

        // Writeback to a non-busy register
        regwr = 1'b1; rd = 5'd11; rddata = 32'h0BADF00D;
        step();
        idle();
        rs = {5'd4, 5'd11};
        settle();
        expect_val("nonbusy_wb_data", 32'h0BADF00D); check(d_rsdata[31:0]);
        expect_val("nonbusy_wb_p1", 32'h44444444);   check(d_rsdata[63:32]);
        expect_val("nonbusy_wb_busy", 32'h0);        check(d_busy_vec);

        // Issue to reg0 never sets its bit
        issue = 1'b1; issue_rd = 5'd0;
        step();
        idle();
        rs = {5'd0, 5'd0};
        settle();
        expect_val("issue_reg0", 32'h0);          check(d_busy_vec);
        expect_val("reg0_rsbusy", 32'h0);         check({30'b0, d_rsbusy});

        // Small instance: three ports, 16 registers, 8-bit data
        s_regwr = 1'b1; s_rd = 4'd15; s_rddata = 8'h3C;
        step();
        s_regwr = 1'b0;
        s_rs = {4'd15, 4'd15, 4'd15};
        settle();
        expect_val("small_3ports", 32'h003C3C3C); check({8'b0, s_rsdata});
        s_issue = 1'b1; s_issue_rd = 4'd15;
        step();
        s_issue = 1'b0;
        settle();
        expect_val("small_busy_vec", 32'h0000_8000); check({16'b0, s_busy_vec});
        expect_val("small_rsbusy", 32'h7);           check({29'b0, s_rsbusy});

        checks++;
        assert (exp_q.size() == 0) else begin
            failures++;
            $error("FAIL queue_drained observed=%0d expected=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised multi-read-port register file with write-through bypass, hardwired-zero register 0 and a per-register pending-write scoreboard. It sits between the decode/issue stage and writeback of the pipelined RISC-V core. Decode reads operands and busy status. Issue marks the destination pending. Writeback stores the data and clears the pending bit.

Parameters:
ADDRSIZE, 5, register address width; the file holds 2**ADDRSIZE registers.
WORDSIZE, 32, data width in bits.
NREAD, 2, number of independent read ports (1..4).
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and is never busy.
BYPASS, 1, 1 = same-cycle writeback data is forwarded to matching read ports.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
regwr  in  1  writeback enable
rd  in  ADDRSIZE  writeback address
rddata  in  WORDSIZE  writeback data
rs  in  NREAD*ADDRSIZE  read addresses; port k uses bits [k*ADDRSIZE +: ADDRSIZE]
rsdata  out  NREAD*WORDSIZE  read data, same packing as rs
rsbusy  out  NREAD  per-port busy flag for the addressed register
issue  in  1  mark issue_rd pending
issue_rd  in  ADDRSIZE  destination being issued
flush  in  1  clear all pending bits (pipeline flush)
busy_vec  out  2**ADDRSIZE  full scoreboard state

Behaviour:
- Reset (rst_n low, asynchronous): all registers = 0, all busy bits = 0. rsdata then shows 0 for every port and rsbusy = 0. Reset asserted mid-operation discards any in-flight write in that cycle.
- Write: on posedge clk with regwr=1, reg[rd] <= rddata, one-cycle latency to storage. If ZERO_REG=1 and rd=0, the write is dropped.
- Read: combinational, zero latency. Per port k:
  - If ZERO_REG=1 and rs_k=0: rsdata_k=0 and rsbusy_k=0.
  - Else if BYPASS=1, regwr=1 and rd=rs_k: rsdata_k=rddata and rsbusy_k=0.
  - Else: rsdata_k=reg[rs_k] and rsbusy_k=busy[rs_k].
  - With BYPASS=0, a same-cycle read returns the old value and the current busy bit.
- Scoreboard update at posedge clk, priority lowest to highest:
  1. flush clears all bits.
  2. regwr clears busy[rd].
  3. issue sets busy[issue_rd].
- Scoreboard boundary cases:
  - Issue and writeback to the same register in the same cycle: the register ends busy (the new producer wins).
  - flush and issue in the same cycle: only busy[issue_rd] is set afterwards.
  - Issuing a register that is already busy (WAW): it stays busy and a single writeback clears it.
  - Register 0 is never set busy when ZERO_REG=1.
- Writeback to a non-busy register is legal: data is written and busy stays 0.
- All read ports are fully independent. Duplicate addresses across ports return identical data.

Decomposition:
- Package rf_pkg:
  - default ADDRSIZE/WORDSIZE localparams
  - ZERO_ADDR constant
  - helper functions for slicing packed port vectors
- Sub-module rf_scoreboard: holds the busy bits and implements the flush/regwr/issue priority; outputs busy_vec.
- regfile_sb: instantiates rf_scoreboard and contains the storage array, the write logic and the per-port read/bypass muxes, generated over NREAD.

Test Plan:
- Reset with default parameters: assert rst_n=0 mid-run after writing reg5=0xDEADBEEF -> every rsdata=0, rsbusy=0, busy_vec=0. Release rst_n; read reg5 -> 0.
- Write/read: write reg3=0x12345678, next cycle rs0=3, rs1=3 -> both ports 0x12345678. Write rd=0 with 0xFFFFFFFF -> reading reg0 returns 0.
- Bypass: in the same cycle regwr=1, rd=7, rddata=0xA5A5A5A5, rs0=7 -> rsdata0=0xA5A5A5A5, rsbusy0=0. Repeat with BYPASS=0 -> old value is returned.
- Scoreboard: issue rd=9 -> next cycle rsbusy for reg9 = 1. Writeback rd=9 -> reg9 not busy in the cycle after (and already 0 same-cycle via bypass).
- Simultaneous events:
  - issue=9 and regwr rd=9 in one cycle -> busy_vec[9]=1 afterwards.
  - flush with issue=4 while regs 2, 4 and 6 are busy -> busy_vec has only bit 4 set.
  - issue rd=0 -> busy_vec[0] stays 0.
- Parameter sweep: ADDRSIZE=4, WORDSIZE=8, NREAD=3. Write reg15=0x3C, read it on all three ports -> 0x3C on each. busy_vec is 16 bits wide.
